pc_gen: RTL and testbench

- Next-generation IF-stage PC generator.
- Owns the fetch PC and picks the next PC by priority: flush > branch > sequential.
- Drives a single-outstanding SRAM-like instruction request (req / addr_ok / data_ok) and tracks the in-flight fetch.
- Discards responses made stale by a redirect; parametrised in PC width, reset vector and step.

---
 rtl/pc_gen.sv | 103 ++++++++++
 tb/tb_pc_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// IF-stage PC generator: owns the fetch PC, picks flush > branch > sequential,
// and drives a single-outstanding instruction request while dropping stale responses.
module pc_gen #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'hBFC0_0000),
  parameter int unsigned          PC_STEP      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [PC_WIDTH-1:0] flush_pc_i,
  input  logic                branch_i,
  input  logic [PC_WIDTH-1:0] branch_pc_i,
  output logic                inst_req_o,
  output logic [PC_WIDTH-1:0] inst_addr_o,
  input  logic                inst_addr_ok_i,
  input  logic                inst_data_ok_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] fetch_pc_o,
  output logic                fetch_valid_o,
  output logic                addr_error_o,
  output logic                ce_o
);

  localparam int unsigned AlignBits = $clog2(PC_STEP);

  typedef enum logic [0:0] {StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  discard_q, discard_d;

  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  issue;
  logic                  valid;

  assign redirect     = flush_i | branch_i;
  assign redirect_pc  = flush_i ? flush_pc_i : branch_pc_i;
  assign addr_error_o = |pc_q[AlignBits-1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    issue      = 1'b0;
    valid      = 1'b0;
    unique case (state_q)
      StReq: begin
        issue = ~stall_i & ~addr_error_o & ~redirect;
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (issue && inst_addr_ok_i) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_WIDTH'(PC_STEP);
          state_d    = StWait;
        end else if (addr_error_o) begin
          // Expose the faulting PC so the exception path can report it.
          fetch_pc_d = pc_q;
        end
      end
      StWait: begin
        valid = inst_data_ok_i & ~discard_q & ~redirect;
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (inst_data_ok_i) begin
          discard_d = 1'b0;
          state_d   = StReq;
        end else if (redirect) begin
          // The in-flight response is now stale; swallow it when it lands.
          discard_d = 1'b1;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StReq;
      pc_q       <= RESET_VECTOR;
      fetch_pc_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign inst_req_o    = issue & ~rst_i;
  assign fetch_valid_o = valid & ~rst_i;
  assign inst_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign ce_o          = ~rst_i;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: outstanding-fetch queue model checked every cycle, plus
// directed literal checks covering sequencing, stalls, redirects, misalignment and wrap.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, flush_i, branch_i, inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] flush_pc_i, branch_pc_i;
  logic        inst_req_o, fetch_valid_o, addr_error_o, ce_o;
  logic [31:0] inst_addr_o, pc_o, fetch_pc_o;

  int total  = 0;
  int passed = 0;

  pc_gen #(
    .PC_WIDTH     (32),
    .RESET_VECTOR (32'hBFC0_0000),
    .PC_STEP      (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .branch_i       (branch_i),
    .branch_pc_i    (branch_pc_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .pc_o           (pc_o),
    .fetch_pc_o     (fetch_pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .addr_error_o   (addr_error_o),
    .ce_o           (ce_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // Model: a queue of accepted fetches, each marked stale once a redirect overtakes it.
  typedef struct packed {logic [31:0] pc; logic stale;} ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_fpc;
  bit          m_valid = 0;

  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      chk("m_req_rst", {31'd0, inst_req_o}, 32'd0);
      chk("m_fv_rst", {31'd0, fetch_valid_o}, 32'd0);
      chk("m_ce_rst", {31'd0, ce_o}, 32'd0);
      q.delete();
      m_pc    = 32'hBFC0_0000;
      m_fpc   = 32'd0;
      m_valid = 1;
    end else if (m_valid) begin
      bit          redir, aligned, idle, e_req, e_fv;
      logic [31:0] tgt;
      redir   = flush_i || branch_i;
      tgt     = flush_i ? flush_pc_i : branch_pc_i;
      aligned = (m_pc % 4) == 0;
      idle    = q.size() == 0;
      e_req   = idle && !stall_i && aligned && !redir;
      e_fv    = inst_data_ok_i && !idle && !q[0].stale && !redir;
      chk("m_req", {31'd0, inst_req_o}, {31'd0, e_req});
      chk("m_addr", inst_addr_o, m_pc);
      chk("m_pc", pc_o, m_pc);
      chk("m_fetch_pc", fetch_pc_o, m_fpc);
      chk("m_fv", {31'd0, fetch_valid_o}, {31'd0, e_fv});
      chk("m_err", {31'd0, addr_error_o}, {31'd0, !aligned});
      chk("m_ce", {31'd0, ce_o}, 32'd1);
      if (inst_data_ok_i && !idle) void'(q.pop_front());
      if (redir) begin
        foreach (q[i]) q[i].stale = 1'b1;
        m_pc = tgt;
      end else if (e_req && inst_addr_ok_i) begin
        q.push_back('{pc: m_pc, stale: 1'b0});
        m_fpc = m_pc;
        m_pc  = m_pc + 32'd4;
      end else if (!aligned && idle) begin
        m_fpc = m_pc;
      end
    end
  end

  task automatic setin(input logic rst, input logic st, input logic fl, input logic [31:0] fpc,
                       input logic br, input logic [31:0] bpc, input logic aok, input logic dok);
    rst_i = rst; stall_i = st; flush_i = fl; flush_pc_i = fpc;
    branch_i = br; branch_pc_i = bpc; inst_addr_ok_i = aok; inst_data_ok_i = dok;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Z = 32'd0;

  initial begin
    setin(1, 0, 0, Z, 0, Z, 0, 0);
    chk("rst_req", {31'd0, inst_req_o}, 32'd0);
    chk("rst_ce", {31'd0, ce_o}, 32'd0);
    tick(); tick();
    chk("rst_pc", pc_o, 32'hBFC0_0000);
    chk("rst_fetch_pc", fetch_pc_o, 32'd0);

    // Three back-to-back sequential fetches
    for (int i = 0; i < 3; i++) begin
      setin(0, 0, 0, Z, 0, Z, 1, 0);
      chk("seq_req", {31'd0, inst_req_o}, 32'd1);
      chk("seq_addr", inst_addr_o, 32'hBFC0_0000 + 32'(i * 4));
      tick();
      setin(0, 0, 0, Z, 0, Z, 0, 1);
      chk("seq_req_wait", {31'd0, inst_req_o}, 32'd0);
      chk("seq_fv", {31'd0, fetch_valid_o}, 32'd1);
      chk("seq_fetch_pc", fetch_pc_o, 32'hBFC0_0000 + 32'(i * 4));
      tick();
    end

    // Stall blocks issue for three cycles
    for (int i = 0; i < 3; i++) begin
      setin(0, 1, 0, Z, 0, Z, 1, 0);
      chk("stall_req", {31'd0, inst_req_o}, 32'd0);
      tick();
      chk("stall_pc", pc_o, 32'hBFC0_000C);
    end
    setin(0, 0, 0, Z, 0, Z, 1, 0);
    chk("unstall_addr", inst_addr_o, 32'hBFC0_000C);
    chk("unstall_req", {31'd0, inst_req_o}, 32'd1);
    tick();
    // Response during a stall is still delivered
    setin(0, 1, 0, Z, 0, Z, 0, 1);
    chk("stall_fv", {31'd0, fetch_valid_o}, 32'd1);
    tick();

    // Branch during wait; stale response arrives two cycles later
    setin(0, 0, 0, Z, 0, Z, 1, 0); tick();
    setin(0, 0, 0, Z, 1, 32'hBFC0_0100, 0, 0);
    chk("br_wait_fv", {31'd0, fetch_valid_o}, 32'd0);
    tick();
    setin(0, 0, 0, Z, 0, Z, 0, 0);
    chk("br_wait_req", {31'd0, inst_req_o}, 32'd0);
    tick();
    setin(0, 0, 0, Z, 0, Z, 0, 1);
    chk("stale_fv", {31'd0, fetch_valid_o}, 32'd0);
    tick();
    setin(0, 0, 0, Z, 0, Z, 1, 0);
    chk("br_addr", inst_addr_o, 32'hBFC0_0100);
    tick();

    // Flush and branch together with data_ok: flush wins, response dropped
    setin(0, 0, 1, 32'hBFC0_0380, 1, 32'hBFC0_0200, 0, 1);
    chk("fl_br_fv", {31'd0, fetch_valid_o}, 32'd0);
    tick();
    setin(0, 0, 0, Z, 0, Z, 1, 0);
    chk("fl_addr", inst_addr_o, 32'hBFC0_0380);
    tick();
    setin(0, 0, 0, Z, 0, Z, 0, 1);
    chk("fl_fetch_pc", fetch_pc_o, 32'hBFC0_0380);
    tick();

    // Misaligned branch target: error, no request, fault PC captured
    setin(0, 0, 0, Z, 1, 32'hBFC0_0102, 1, 0); tick();
    setin(0, 0, 0, Z, 0, Z, 1, 0);
    chk("mis_err", {31'd0, addr_error_o}, 32'd1);
    chk("mis_req", {31'd0, inst_req_o}, 32'd0);
    tick();
    chk("mis_fetch_pc", fetch_pc_o, 32'hBFC0_0102);
    setin(0, 0, 1, 32'hBFC0_0380, 0, Z, 0, 0); tick();
    setin(0, 0, 0, Z, 0, Z, 1, 0);
    chk("mis_clr_err", {31'd0, addr_error_o}, 32'd0);
    chk("mis_clr_addr", inst_addr_o, 32'hBFC0_0380);
    tick();
    setin(0, 0, 0, Z, 0, Z, 0, 1); tick();

    // Two redirects while waiting: last wins
    setin(0, 0, 0, Z, 0, Z, 1, 0); tick();
    setin(0, 0, 0, Z, 1, 32'hBFC0_0500, 0, 0); tick();
    setin(0, 0, 0, Z, 1, 32'hBFC0_0600, 0, 0); tick();
    setin(0, 0, 0, Z, 0, Z, 0, 1);
    chk("two_br_fv", {31'd0, fetch_valid_o}, 32'd0);
    tick();
    chk("two_br_pc", pc_o, 32'hBFC0_0600);

    // Redirect honoured under stall
    setin(0, 1, 0, Z, 1, 32'hFFFF_FFFC, 0, 0); tick();
    chk("stall_br_pc", pc_o, 32'hFFFF_FFFC);

    // Wrap at top of address space, then reset mid-fetch
    setin(0, 0, 0, Z, 0, Z, 1, 0);
    chk("wrap_addr", inst_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc_o, 32'h0000_0000);
    setin(1, 0, 0, Z, 0, Z, 0, 0);
    chk("rst_wait_req", {31'd0, inst_req_o}, 32'd0);
    tick();
    setin(0, 0, 0, Z, 0, Z, 0, 1);
    chk("rst2_pc", pc_o, 32'hBFC0_0000);
    chk("late_fv", {31'd0, fetch_valid_o}, 32'd0);
    chk("rst2_req", {31'd0, inst_req_o}, 32'd1);
    tick();
    setin(0, 0, 0, Z, 0, Z, 1, 0); tick();
    setin(0, 0, 0, Z, 0, Z, 0, 1);
    chk("post_rst_fv", {31'd0, fetch_valid_o}, 32'd1);
    chk("post_rst_fetch_pc", fetch_pc_o, 32'hBFC0_0000);
    tick();
    setin(0, 0, 0, Z, 0, Z, 0, 0); tick();
    #10;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
